// File: rtl/rv32_fetch_pkg.sv
// Shared RV32 front-end definitions: opcode constants, the canonical NOP
// and the fetch-stage state encoding.
package rv32_fetch_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        F_REQ,
        F_WAIT,
        F_HOLD,
        F_DROP
    } fetch_state_e;

endpackage

// File: rtl/rv32_f_pc_unit.sv
// Fetch program counter: register, next-PC select and the +4 incrementer.
// A redirect always wins over a sequential advance.
module rv32_f_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        advance_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (advance_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage: single-outstanding instruction memory
// requests, a one-entry skid buffer for decode stalls, and the fetch-to-decode register.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    output logic        fetch_busy_o
);

    fetch_state_e state_d, state_q;
    logic [31:0]  instr_d, instr_q;
    logic [31:0]  dpc_d, dpc_q;
    logic [31:0]  dpc_next_d, dpc_next_q;
    logic [31:0]  skid_d, skid_q;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         advance;
    logic         dec_write;
    logic [31:0]  dec_instr;

    rv32_f_pc_unit #(
        .RESET_PC(RESET_PC)
    ) u_pc_unit (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .advance_i    (advance),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (pc),
        .pc_plus4_o   (pc_plus4)
    );

    // A redirect suppresses the request so a grant can never race the PC reload.
    assign imem_req_o   = rst_n_i && (state_q == F_REQ) && !stall_f_i && !redirect_i;
    assign imem_addr_o  = pc;
    assign fetch_busy_o = rst_n_i && (((state_q == F_REQ)  && !imem_gnt_i)    ||
                                      ((state_q == F_WAIT) && !imem_rvalid_i) ||
                                       (state_q == F_DROP));

    always_comb begin
        state_d    = state_q;
        skid_d     = skid_q;
        advance    = 1'b0;
        dec_write  = 1'b0;
        dec_instr  = imem_rdata_i;

        unique case (state_q)
            F_REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? F_REQ : F_DROP;
                end else if (imem_rvalid_i) begin
                    if (stall_d_i && !flush_d_i) begin
                        skid_d  = imem_rdata_i;
                        state_d = F_HOLD;
                    end else begin
                        dec_write = 1'b1;
                        advance   = 1'b1;
                        state_d   = F_REQ;
                    end
                end
            end
            F_HOLD: begin
                if (redirect_i) begin
                    skid_d  = '0;
                    state_d = F_REQ;
                end else if (!stall_d_i && !flush_d_i) begin
                    dec_instr = skid_q;
                    dec_write = 1'b1;
                    advance   = 1'b1;
                    skid_d    = '0;
                    state_d   = F_REQ;
                end
            end
            F_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = F_REQ;
                end
            end
            default: state_d = F_REQ;
        endcase

        instr_d    = instr_q;
        dpc_d      = dpc_q;
        dpc_next_d = dpc_next_q;
        if (flush_d_i) begin
            instr_d    = NOP_INSTR;
            dpc_d      = '0;
            dpc_next_d = '0;
        end else if (dec_write) begin
            instr_d    = dec_instr;
            dpc_d      = pc;
            dpc_next_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= F_REQ;
            instr_q    <= NOP_INSTR;
            dpc_q      <= '0;
            dpc_next_q <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            dpc_q      <= dpc_d;
            dpc_next_q <= dpc_next_d;
            skid_q     <= skid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = dpc_q;
    assign pc_next_o = dpc_next_q;

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed bench for rv32_fetch: memory handshakes driven by hand, expected
// values written out per step.
module tb_rv32_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stall_f_i, stall_d_i, flush_d_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o, pc_o, pc_next_o;
    logic        fetch_busy_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk_i = ~clk_i;

    rv32_fetch #(
        .RESET_PC(32'h0000_0100)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .stall_f_i    (stall_f_i),
        .stall_d_i    (stall_d_i),
        .flush_d_i    (flush_d_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_next_o    (pc_next_o),
        .fetch_busy_o (fetch_busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Grant in the current cycle, respond in the next one.
    task automatic fetch(input logic [31:0] data);
        imem_gnt_i = 1'b1;
        #1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] i, input logic [31:0] p);
        check({tag, "_instr"}, instr_o, i);
        check({tag, "_pc"}, pc_o, p);
        check({tag, "_pcnext"}, pc_next_o, p + 32'd4);
    endtask

    initial begin
        rst_n_i = 1'b0; stall_f_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // Reset values
        tick(); tick();
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_busy", {31'd0, fetch_busy_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'd0);
        check("rst_pcnext", pc_next_o, 32'd0);

        // Sequential fetch from RESET_PC with immediate grants
        rst_n_i = 1'b1;
        #1;
        check("first_req", {31'd0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0000_0100);
        check("req_nogrant_busy", {31'd0, fetch_busy_o}, 32'd1);
        imem_gnt_i = 1'b1;
        #1;
        check("req_grant_busy", {31'd0, fetch_busy_o}, 32'd0);
        tick();
        imem_gnt_i = 1'b0;
        #1;
        check("wait_req", {31'd0, imem_req_o}, 32'd0);
        check("wait_busy", {31'd0, fetch_busy_o}, 32'd1);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hA000_0000;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check_dec("seq0", 32'hA000_0000, 32'h0000_0100);
        check("seq0_addr", imem_addr_o, 32'h0000_0104);
        fetch(32'hA000_0001);
        check_dec("seq1", 32'hA000_0001, 32'h0000_0104);
        check("seq1_addr", imem_addr_o, 32'h0000_0108);
        fetch(32'hA000_0002);
        check_dec("seq2", 32'hA000_0002, 32'h0000_0108);
        check("seq2_addr", imem_addr_o, 32'h0000_010C);

        // Decode stall for 3 cycles while a response arrives
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        stall_d_i     = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hB000_0000;
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("hold_instr", instr_o, 32'hA000_0002);
        check("hold_req", {31'd0, imem_req_o}, 32'd0);
        check("hold_busy", {31'd0, fetch_busy_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b0;
        check("hold2_instr", instr_o, 32'hA000_0002);
        tick();
        check("hold3_instr", instr_o, 32'hA000_0002);
        stall_d_i = 1'b0;
        tick();
        check_dec("skid", 32'hB000_0000, 32'h0000_010C);
        check("skid_addr", imem_addr_o, 32'h0000_0110);
        tick();
        check("skid_once_pc", pc_o, 32'h0000_010C);
        fetch(32'hB000_0001);
        check_dec("after_skid", 32'hB000_0001, 32'h0000_0110);

        // Redirect during WAIT; stale response two cycles later
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        tick();
        redirect_i = 1'b0;
        #1;
        check("drop_busy", {31'd0, fetch_busy_o}, 32'd1);
        check("drop_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h57A1_E000;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("redir_instr", instr_o, 32'hB000_0001);
        check("redir_req", {31'd0, imem_req_o}, 32'd1);
        check("redir_addr", imem_addr_o, 32'h0000_2000);
        fetch(32'hC000_0000);
        check_dec("redir_fetch", 32'hC000_0000, 32'h0000_2000);

        // Redirect beats stall_f in REQ
        stall_f_i = 1'b1;
        #1;
        check("stallf_req", {31'd0, imem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3002;
        tick();
        redirect_i = 1'b0;
        check("stallf_redir_addr", imem_addr_o, 32'h0000_3000);
        stall_f_i = 1'b0;
        #1;
        check("stallf_release_req", {31'd0, imem_req_o}, 32'd1);

        // Flush coincident with a response
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hD000_0000;
        flush_d_i     = 1'b1;
        stall_d_i     = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        flush_d_i     = 1'b0;
        stall_d_i     = 1'b0;
        check("flush_instr", instr_o, 32'h0000_0013);
        check("flush_pc", pc_o, 32'd0);
        check("flush_pcnext", pc_next_o, 32'd0);
        check("flush_addr", imem_addr_o, 32'h0000_3004);
        fetch(32'hD000_0001);
        check_dec("post_flush", 32'hD000_0001, 32'h0000_3004);

        // PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        fetch(32'hE000_0000);
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_pcnext", pc_next_o, 32'd0);
        check("wrap_addr", imem_addr_o, 32'd0);

        // Asynchronous reset while WAITing
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_instr", instr_o, 32'h0000_0013);
        check("arst_pc", pc_o, 32'd0);
        check("arst_req", {31'd0, imem_req_o}, 32'd0);
        check("arst_busy", {31'd0, fetch_busy_o}, 32'd0);
        tick();
        rst_n_i       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0000;
        #1;
        check("restart_addr", imem_addr_o, 32'h0000_0100);
        check("restart_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("late_rvalid_instr", instr_o, 32'h0000_0013);
        check("late_rvalid_req", {31'd0, imem_req_o}, 32'd1);
        fetch(32'hF000_0000);
        check_dec("restart_fetch", 32'hF000_0000, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
